// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared types and constants for the instruction memory bank.
package inst_mem_pkg;

  // Loader FSM states
  typedef enum logic [0:0] {
    IMEM_IDLE = 1'b0,
    IMEM_LOAD = 1'b1
  } imem_state_t;

  // Value returned on fetch_instr for an out-of-range fetch
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage : inst_mem_pkg

// File: rtl/inst_mem_array.sv
// inst_mem_array: 1R1W synchronous word store, posedge write, registered read.
// Optional INST_MEM_PARITY_EN: stores an even-parity bit per word and flags mismatches on read.
// Data is kept big endian ([0] is the MSB); the write path is bit-for-bit.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [0:DATA_W-1] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [0:DATA_W-1] rd_data,
  output logic              rd_perr
);

  logic [0:DATA_W-1] mem_q [DEPTH];
  logic [0:DATA_W-1] rd_data_q;

  // Word storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port; rd_clr substitutes the fault fill word, data held when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_clr ? DATA_W'(IMEM_NOP) : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

`ifdef INST_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic rd_perr_q;

  // Parity column written alongside each word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_q[wr_addr] <= ^wr_data;
    end
  end

  // Parity check on read; only meaningful for a real (non-fault) read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_perr_q <= 1'b0;
    end else begin
      rd_perr_q <= rd_en & ~rd_clr & ((^mem_q[rd_addr]) ^ par_q[rd_addr]);
    end
  end

  assign rd_perr = rd_perr_q;
`else
  assign rd_perr = 1'b0;
`endif

endmodule : inst_mem_array

// File: rtl/inst_mem_bank.sv
// inst_mem_bank: instruction memory with a 1-cycle valid/ready fetch port and a streaming
// boot loader that fills consecutive words. Out-of-range addresses fault instead of wrapping.
// Optional INST_MEM_PARITY_EN: per-word parity with fetch_perr reporting (else fetch_perr = 0).
module inst_mem_bank
  import inst_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [0:DATA_W-1] fetch_instr,
  output logic              fetch_fault,
  output logic              fetch_perr,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              load_valid,
  input  logic [0:DATA_W-1] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_err
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  imem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              load_err_q, load_err_d;
  logic              wr_en;
  logic              fetch_ready_q, load_ready_q, load_busy_q;
  logic              fetch_valid_q, fetch_fault_q;
  logic              beat, accept, fetch_oor;

  assign beat      = load_valid & load_ready_q;
  assign accept    = fetch_req & fetch_ready_q;
  assign fetch_oor = (fetch_addr >= DEPTH_A);

  // Loader FSM state, pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IMEM_IDLE;
      ptr_q         <= '0;
      remain_q      <= '0;
      load_err_q    <= 1'b0;
      fetch_ready_q <= 1'b0;
      load_ready_q  <= 1'b0;
      load_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      remain_q      <= remain_d;
      load_err_q    <= load_err_d;
      fetch_ready_q <= (state_d == IMEM_IDLE);
      load_ready_q  <= (state_d == IMEM_LOAD);
      load_busy_q   <= (state_d != IMEM_IDLE);
    end
  end

  // Loader next-state: start in IDLE, one word per accepted beat, out-of-range beats dropped
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    load_err_d = load_err_q;
    wr_en      = 1'b0;
    case (state_q)
      IMEM_IDLE: begin
        if (load_start) begin
          load_err_d = 1'b0;
          if (load_count != '0) begin
            state_d  = IMEM_LOAD;
            ptr_d    = load_base;
            remain_d = load_count;
          end
        end
      end
      IMEM_LOAD: begin
        if (beat) begin
          if (ptr_q >= DEPTH_A) begin
            load_err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
          // Saturate so the pointer can never wrap back into range
          if (ptr_q != '1) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            state_d = IMEM_IDLE;
          end
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // Fetch result qualifiers, one cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_valid_q <= accept;
      fetch_fault_q <= accept & fetch_oor;
    end
  end

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (ptr_q[IDX_W-1:0]),
    .wr_data (load_data),
    .rd_en   (accept),
    .rd_clr  (fetch_oor),
    .rd_addr (fetch_addr[IDX_W-1:0]),
    .rd_data (fetch_instr),
    .rd_perr (fetch_perr)
  );

  assign fetch_ready = fetch_ready_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign load_ready  = load_ready_q;
  assign load_busy   = load_busy_q;
  assign load_err    = load_err_q;

endmodule : inst_mem_bank
